// File: rtl/ddr_wr_dqs_seq.sv
// DDR3 write-burst sequencer: per-clk_div DQS pattern, DQ/DQS tristate nibbles and FWFT pops.
// Handles preamble, burst, postamble and seamless back-to-back bursts.
module ddr_wr_dqs_seq #(
  parameter int unsigned DQ_WIDTH = 8,
  parameter int unsigned LEN_BITS = 4
) (
  input  logic                  clk_div,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_BITS-1:0]   len,
  output logic                  ready,
  output logic                  busy,
  output logic                  data_rd,
  input  logic [4*DQ_WIDTH-1:0] wr_data,
  output logic [4*DQ_WIDTH-1:0] dq_din,
  output logic [3:0]            dq_tin,
  output logic [3:0]            dqs_din,
  output logic [3:0]            dqs_tin
);

  typedef enum logic [1:0] {StIdle, StPre, StBurst, StPost} state_e;

  state_e                state_q, state_d;
  logic [LEN_BITS-1:0]   cnt_q, cnt_d;
  logic [4*DQ_WIDTH-1:0] dq_din_q;
  logic [3:0]            dq_tin_q, dq_tin_d;
  logic [3:0]            dqs_din_q, dqs_din_d;
  logic [3:0]            dqs_tin_q, dqs_tin_d;

  always_comb begin
    ready = (state_q == StIdle) || (state_q == StPost) ||
            ((state_q == StBurst) && (cnt_q == '0));
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPre;
          cnt_d   = len;
        end
      end
      StPre: state_d = StBurst;
      StBurst: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_BITS'(1);
        end else if (start) begin
          cnt_d = len;
        end else begin
          state_d = StPost;
        end
      end
      StPost: begin
        // Postamble drives DQS low first, so it doubles as the next burst's preamble.
        if (start) begin
          state_d = StBurst;
          cnt_d   = len;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dqs_tin_d = 4'b1111;
    dqs_din_d = 4'b0000;
    dq_tin_d  = 4'b1111;
    unique case (state_d)
      StIdle: ;
      StPre: dqs_tin_d = 4'b0000;
      StBurst: begin
        dqs_tin_d = 4'b0000;
        dqs_din_d = 4'b0101;
        dq_tin_d  = 4'b0000;
      end
      StPost: dqs_tin_d = 4'b1100;
      default: ;
    endcase
  end

  assign data_rd = (state_d == StBurst) && rst_n;
  assign busy    = (state_q != StIdle);

  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dq_din_q  <= '0;
      dq_tin_q  <= 4'b1111;
      dqs_din_q <= 4'b0000;
      dqs_tin_q <= 4'b1111;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_tin_q  <= dq_tin_d;
      dqs_din_q <= dqs_din_d;
      dqs_tin_q <= dqs_tin_d;
      if (data_rd) begin
        dq_din_q <= wr_data;
      end
    end
  end

  assign dq_din  = dq_din_q;
  assign dq_tin  = dq_tin_q;
  assign dqs_din = dqs_din_q;
  assign dqs_tin = dqs_tin_q;

endmodule
